morse_element_sequencer: RTL and testbench

Converts one encoded Morse character per handshake into correctly timed `dit`/`dah` mark levels and silent gaps, using standard unit ratios. It sits directly upstream of the tone generator and drives its `dit`/`dah` inputs. It receives characters from the keyboard-to-Morse lookup stage. `clk` is the 1 MHz system clock.

---
 rtl/morse_pkg.sv | 37 +++
 rtl/morse_element_sequencer_if.sv | 10 +
 rtl/morse_unit_timer.sv | 56 +++++
 rtl/morse_element_sequencer.sv | 156 +++++++++++++++
 tb/tb_morse_element_sequencer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse element sequencer.
package morse_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMark,
    StElemGap,
    StCharGap,
    StWordGap
  } state_e;

  localparam int unsigned DIT_UNITS      = 1;
  localparam int unsigned DAH_UNITS      = 3;
  localparam int unsigned ELEM_GAP_UNITS = 1;
  localparam int unsigned CHAR_GAP_UNITS = 3;
  localparam int unsigned WORD_GAP_UNITS = 4;
  localparam int unsigned MAX_ELEMS      = 5;

  // Lengths above the longest Morse character are treated as the longest one.
  function automatic logic [2:0] clamp_len(input logic [2:0] l);
    return (l > 3'(MAX_ELEMS)) ? 3'(MAX_ELEMS) : l;
  endfunction

  // Duration of a state in units; a mark depends on the element it shows.
  function automatic logic [2:0] state_units(input state_e s, input logic is_dah);
    logic [2:0] u;
    case (s)
      StMark:    u = is_dah ? 3'(DAH_UNITS) : 3'(DIT_UNITS);
      StElemGap: u = 3'(ELEM_GAP_UNITS);
      StCharGap: u = 3'(CHAR_GAP_UNITS);
      StWordGap: u = 3'(WORD_GAP_UNITS);
      default:   u = 3'd1;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/morse_element_sequencer_if.sv
// Character handshake between the keyboard-to-Morse lookup and the sequencer.
interface morse_element_sequencer_if;
  logic [4:0] code;
  logic [2:0] len;
  logic       valid;
  logic       ready;

  modport master (output code, output len, output valid, input ready);
  modport slave  (input code, input len, input valid, output ready);
endinterface

// File: rtl/morse_unit_timer.sv
// Tick and unit counters for the sequencer. The tick counter wraps every
// UNIT_TICKS cycles; the unit counter counts completed units in a state.
// pre_tick flags the cycle before unit_tick so the owner can register
// outputs that must change on the last cycle of a unit.
module morse_unit_timer #(
  parameter int unsigned UNIT_TICKS = 60000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  output logic       unit_tick,
  output logic       pre_tick,
  output logic [2:0] unit_cnt
);

  localparam logic [CNT_W-1:0] TickLast = CNT_W'(UNIT_TICKS - 1);
  localparam logic [CNT_W-1:0] TickPre  = CNT_W'(UNIT_TICKS - 2);

  logic [CNT_W-1:0] tick_q, tick_d;
  logic [2:0]       unit_q, unit_d;

  assign unit_tick = enable && (tick_q == TickLast);
  assign pre_tick  = enable && (tick_q == TickPre);
  assign unit_cnt  = unit_q;

  // Next counter values; clear wins over counting.
  always_comb begin
    tick_d = tick_q;
    unit_d = unit_q;
    if (clear) begin
      tick_d = '0;
      unit_d = '0;
    end else if (enable) begin
      if (tick_q == TickLast) begin
        tick_d = '0;
        unit_d = unit_q + 3'd1;
      end else begin
        tick_d = tick_q + CNT_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
      unit_q <= '0;
    end else begin
      tick_q <= tick_d;
      unit_q <= unit_d;
    end
  end

endmodule

// File: rtl/morse_element_sequencer.sv
// Morse element sequencer: turns one encoded character per handshake into
// timed dit/dah mark levels and silent gaps for the tone generator.
// Optional feature macro: MORSE_ABORT_EN adds an abort input that returns
// the sequencer to idle from any active state.
// ready is raised during the last cycle of a character/word gap so a held
// valid is taken on the edge that ends the gap, with no idle cycle between.
module morse_element_sequencer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_TICKS = 60000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  morse_element_sequencer_if.slave hs,
`ifdef MORSE_ABORT_EN
  input  logic                     abort,
`endif
  output logic                     dit,
  output logic                     dah,
  output logic                     busy
);

  state_e     state_q, state_d;
  logic [4:0] code_q, code_d;
  logic [2:0] len_q, len_d;
  logic [2:0] idx_q, idx_d;
  logic       ready_q, ready_d;
  logic       dit_q, dit_d;
  logic       dah_q, dah_d;

  logic       clear, enable;
  logic       unit_tick, pre_tick;
  logic [2:0] unit_cnt;
  logic [2:0] units;
  logic       last_unit;
  logic       done;
  logic       in_gap;
  logic       load;
  logic       abort_req;
  logic       next_bit;

  morse_unit_timer #(
    .UNIT_TICKS(UNIT_TICKS),
    .CNT_W     (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .enable   (enable),
    .unit_tick(unit_tick),
    .pre_tick (pre_tick),
    .unit_cnt (unit_cnt)
  );

`ifdef MORSE_ABORT_EN
  assign abort_req = abort && (state_q != StIdle);
`else
  assign abort_req = 1'b0;
`endif

  assign enable    = (state_q != StIdle);
  assign units     = state_units(state_q, code_q[idx_q]);
  assign last_unit = (unit_cnt == (units - 3'd1));
  assign done      = unit_tick && last_unit;
  assign in_gap    = (state_q == StCharGap) || (state_q == StWordGap);

  // Next state, latched character and timer clear.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    len_d   = len_q;
    idx_d   = idx_q;
    clear   = 1'b0;
    load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (hs.valid && ready_q) load = 1'b1;
      end
      StMark: begin
        if (done) begin
          clear   = 1'b1;
          state_d = ((idx_q + 3'd1) < len_q) ? StElemGap : StCharGap;
        end
      end
      StElemGap: begin
        if (done) begin
          clear   = 1'b1;
          idx_d   = idx_q + 3'd1;
          state_d = StMark;
        end
      end
      StCharGap, StWordGap: begin
        if (done) begin
          clear = 1'b1;
          if (hs.valid && ready_q) load = 1'b1;
          else state_d = StIdle;
        end
      end
      default: begin
        clear   = 1'b1;
        state_d = StIdle;
      end
    endcase

    if (load) begin
      clear   = 1'b1;
      code_d  = hs.code;
      len_d   = clamp_len(hs.len);
      idx_d   = 3'd0;
      state_d = (hs.len == 3'd0) ? StWordGap : StMark;
    end

    if (abort_req) begin
      clear   = 1'b1;
      state_d = StIdle;
    end
  end

  // Registered outputs decoded from the next state.
  always_comb begin
    next_bit = code_d[idx_d];
    dit_d    = (state_d == StMark) && !next_bit;
    dah_d    = (state_d == StMark) && next_bit;
    ready_d  = (state_d == StIdle) ||
               (in_gap && !clear && pre_tick && last_unit);
  end

  // State, character and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      code_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      ready_q <= 1'b1;
      dit_q   <= 1'b0;
      dah_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      dit_q   <= dit_d;
      dah_q   <= dah_d;
    end
  end

  assign hs.ready = ready_q;
  assign dit      = dit_q;
  assign dah      = dah_q;
  assign busy     = ~ready_q;

endmodule

// File: tb/tb_morse_element_sequencer.sv
// Self-checking bench for morse_element_sequencer with UNIT_TICKS=4.
module tb_morse_element_sequencer;

  localparam int unsigned U = 4;

  logic clk;
  logic rst_n;
  logic abort;
  logic dit, dah, busy;

  morse_element_sequencer_if hs ();

  morse_element_sequencer #(
    .UNIT_TICKS(U),
    .CNT_W     (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hs   (hs),
`ifdef MORSE_ABORT_EN
    .abort(abort),
`endif
    .dit  (dit),
    .dah  (dah),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected per-cycle {dit, dah, ready} for the active character.
  logic [2:0] tl[$];
  logic [2:0] cur = 3'b001;
  bit         act = 1'b0;

  // Mark/gap monitors used by the literal checks.
  int  silent_run = 0;
  int  last_gap = 0;
  bit  seen_mark = 1'b0;
  int  dah_pulses = 0;
  logic dah_prev = 1'b0;

  task automatic chk(input string nm, input int actual, input int req);
    checks++;
    if (actual != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, actual, req);
    end
  endtask

  // Timeline of a freshly accepted character from the unit-ratio rules.
  task automatic model_accept(input logic [4:0] c, input logic [2:0] l);
    int n;
    logic b;
    n = (l > 3'd5) ? 5 : int'(l);
    if (n == 0) begin
      repeat (4 * U) tl.push_back(3'b000);
    end else begin
      for (int e = 0; e < n; e++) begin
        b = c[e];
        repeat ((b ? 3 : 1) * U) tl.push_back(b ? 3'b010 : 3'b100);
        if (e < n - 1) repeat (U) tl.push_back(3'b000);
      end
      repeat (3 * U) tl.push_back(3'b000);
    end
    tl[tl.size() - 1] = 3'b001;
  endtask

  // Model advance and per-cycle compare, sampled 1 time unit after each edge.
  initial begin
    bit abt;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
`ifdef MORSE_ABORT_EN
      abt = abort && act;
`else
      abt = 1'b0;
`endif
      if (!rst_n) begin
        tl.delete();
        cur = 3'b001;
        act = 1'b0;
        seen_mark = 1'b0;
      end else begin
        if (abt) tl.delete();
        else if (hs.valid && cur[0]) model_accept(hs.code, hs.len);
        if (tl.size() > 0) begin
          cur = tl.pop_front();
          act = 1'b1;
        end else begin
          cur = 3'b001;
          act = 1'b0;
        end
      end
      checks++;
      if ({dit, dah, hs.ready, busy} !== {cur, ~cur[0]}) begin
        errors++;
        $display("FAIL cycle %0d dit/dah/ready/busy: got %b, required %b", cyc,
                 {dit, dah, hs.ready, busy}, {cur, ~cur[0]});
      end
      if (dit || dah) begin
        if (seen_mark && silent_run > 0) last_gap = silent_run;
        silent_run = 0;
        seen_mark = 1'b1;
      end else begin
        silent_run++;
      end
      if (dah && !dah_prev) dah_pulses++;
      dah_prev = dah;
    end
  end

  task automatic wait_ready(input int lim);
    bit ok = 1'b0;
    for (int k = 0; k < lim && !ok; k++) begin
      @(negedge clk);
      if (hs.ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: ready 0 for %0d cycles, required 1", lim);
    end
  endtask

  // Send one character and count mark cycles and cycles until ready returns.
  task automatic send_measure(input logic [4:0] c, input logic [2:0] l, input int e_dit,
                              input int e_dah, input int e_tot, input string nm,
                              input bit hold);
    int  nd = 0;
    int  nh = 0;
    int  tot = 0;
    bit  done = 1'b0;
    wait_ready(200);
    hs.code  = c;
    hs.len   = l;
    hs.valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 300 && !done; k++) begin
      #1;
      tot++;
      nd += int'(dit);
      nh += int'(dah);
      if (hs.ready) begin
        done = 1'b1;
      end else begin
        @(negedge clk);
        if (!hold) hs.valid = 1'b0;
        @(posedge clk);
      end
    end
    chk({nm, " ready returned"}, int'(done), 1);
    chk({nm, " dit cycles"}, nd, e_dit);
    chk({nm, " dah cycles"}, nh, e_dah);
    chk({nm, " cycles to ready"}, tot, e_tot);
  endtask

  initial begin
    int p0;
    bit hit;
    rst_n    = 1'b0;
    abort    = 1'b0;
    hs.valid = 1'b0;
    hs.code  = '0;
    hs.len   = '0;

    #12;
    chk("reset dit", int'(dit), 0);
    chk("reset dah", int'(dah), 0);
    chk("reset ready", int'(hs.ready), 1);
    chk("reset busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    send_measure(5'b00000, 3'd1, 4, 0, 16, "E", 1'b0);
    send_measure(5'b00010, 3'd2, 4, 12, 32, "A", 1'b0);

    // T then word space then E: 3 + 4 units of silence between marks.
    send_measure(5'b00001, 3'd1, 0, 12, 24, "T", 1'b0);
    send_measure(5'b00000, 3'd0, 0, 0, 16, "space", 1'b0);
    send_measure(5'b00000, 3'd1, 4, 0, 16, "E after space", 1'b0);
    chk("T-space-E silence", last_gap, 28);

    // valid held through the first T.
    send_measure(5'b00001, 3'd1, 0, 12, 24, "T held", 1'b1);
    send_measure(5'b00001, 3'd1, 0, 12, 24, "T second", 1'b0);
    chk("T-T silence", last_gap, 12);

    p0 = dah_pulses;
    send_measure(5'b11111, 3'd7, 0, 60, 88, "len7", 1'b0);
    chk("len7 dah pulses", dah_pulses - p0, 5);

    // Reset in the middle of a dah.
    wait_ready(200);
    hs.code  = 5'b11111;
    hs.len   = 3'd7;
    hs.valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hs.valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("dah before reset", int'(dah), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid reset dit", int'(dit), 0);
    chk("mid reset dah", int'(dah), 0);
    chk("mid reset ready", int'(hs.ready), 1);
    chk("mid reset busy", int'(busy), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_measure(5'b00000, 3'd1, 4, 0, 16, "E after reset", 1'b0);

`ifdef MORSE_ABORT_EN
    wait_ready(200);
    hs.code  = 5'b00010;
    hs.len   = 3'd2;
    hs.valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hs.valid = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      if (dah) hit = 1'b1;
      else @(negedge clk);
    end
    chk("A reached dah", int'(hit), 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort dah", int'(dah), 0);
    chk("abort ready", int'(hs.ready), 1);
    @(negedge clk);
    abort = 1'b0;
    send_measure(5'b00000, 3'd1, 4, 0, 16, "E after abort", 1'b0);
`else
    hit = 1'b0;
`endif

    // Random characters, lengths and valid patterns against the model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      hs.valid = ($urandom_range(0, 3) != 0);
      hs.code  = 5'($urandom);
      hs.len   = 3'($urandom);
`ifdef MORSE_ABORT_EN
      abort = ($urandom_range(0, 59) == 0);
`endif
    end
    @(negedge clk);
    hs.valid = 1'b0;
    abort    = 1'b0;
    wait_ready(200);
    repeat (2) @(posedge clk);
    #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
